mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single memory port between instruction fetch (IF) and load/store (D).
//  Sits between the fetch/LSU stages and the memory bus.
//  Arbitrates requests and latches the winner's address, write data and byte enables.
//  Drives the address-mux select, sequences one outstanding bus transaction, and routes the response back to its owner.
//  Data side has priority; a streak limit prevents fetch starvation; a wait-state watchdog aborts hung transactions.
// PARAMETERS
//  MAX_D_STREAK  4    consecutive D grants allowed while if_req is pending before IF must win (>=1)
//  TIMEOUT_CYC   64   BUSY cycles without mem_ready before abort; 0 disables the watchdog
// PORTS
//  clk        in   1        core clock, all logic on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  if_req     in   1        fetch request; held with if_addr until if_gnt
//  if_addr    in   XLEN     fetch address (PC)
//  if_gnt     out  1        one-cycle pulse: fetch request accepted
//  if_rvalid  out  1        one-cycle pulse: fetch response valid
//  d_req      in   1        load/store request; held with d_* until d_gnt
//  d_we       in   1        1 = store
//  d_be       in   XLEN/8   store byte enables
//  d_addr     in   XLEN     data address (ALU result)
//  d_wdata    in   XLEN     store data
//  d_gnt      out  1        one-cycle pulse: data request accepted
//  d_rvalid   out  1        one-cycle pulse: load data / store ack valid
//  rsp_rdata  out  XLEN     pass-through of mem_rdata, valid with either rvalid
//  rsp_err    out  1        qualifies rvalid: transaction aborted by watchdog
//  mem_req    out  1        bus request, high for the whole BUSY period
//  mem_we     out  1        latched d_we (0 for fetch)
//  mem_be     out  XLEN/8   latched byte enables (all ones for fetch)
//  mem_addr   out  XLEN     latched address, output of the address mux
//  mem_wdata  out  XLEN     latched store data
//  mem_ready  in   1        bus completes the transaction in this cycle
//  mem_rdata  in   XLEN     read data, valid when mem_ready
//  addr_sel   out  1        address-mux select: 0 = if_addr, 1 = d_addr; registered owner
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched address/data/byte-enable registers 0; streak and wait counters 0.
//  FSM states: IDLE, BUSY_IF, BUSY_D.
//   IDLE: grant D if d_req && !(if_req && streak==MAX_D_STREAK), otherwise grant IF if if_req.
//   IDLE, on a grant: the gnt output pulses combinationally in the same cycle.
//   IDLE, on a grant: addr_sel, mem_* and the owner register are loaded at the clock edge.
//   IDLE, on a grant: the next state is BUSY_IF or BUSY_D.
//   BUSY_x: mem_req=1 with latched mem_* outputs, stable until completion.
//   BUSY_x, when mem_ready=1: owner's rvalid pulses in the same cycle (combinational), rsp_err=0, next state IDLE.
//   BUSY_x, when the wait counter reaches TIMEOUT_CYC-1 without mem_ready: owner's rvalid=1 and rsp_err=1 for one cycle, next state IDLE.
//  Latency: earliest rvalid is 1 cycle after gnt; the back-to-back grant rate is one transaction per 2 cycles.
//  A store still produces d_rvalid (ack); rsp_rdata is don't-care for stores.
//  Streak counter: +1 on each D grant while if_req=1, saturating at MAX_D_STREAK.
//  Streak counter: cleared on an IF grant or on any IDLE cycle with if_req=0.
//  Wait counter: cleared on entry to BUSY, counts each BUSY cycle; XLEN-independent, $clog2(TIMEOUT_CYC+1) bits.
//  If a request is dropped before its gnt, it is not granted and no response is produced.
//  Requests arriving in BUSY are ignored until IDLE; gnt is never asserted outside IDLE.
//  if_gnt and d_gnt are never high together; if_rvalid and d_rvalid are never high together.
//  Reset mid-transaction: the transaction is abandoned; no rvalid is produced; mem_req drops asynchronously.
//  mem_ready in IDLE is ignored.
// STRUCTURE
//  riscv_pkg additions:
//   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_D} arb_state_e;
//   typedef enum logic {OWN_IF, OWN_D} mem_owner_e;
//  The block uses XLEN from riscv_pkg.
//  Sub-modules:
//   The address path is one mx2 instance (A0=if_addr, A1=d_addr, select=grant decision) feeding the mem_addr register.
//   All other logic is inline.
// TESTING
//  Reset check: reset, then if_req=1 with if_addr=0x100 -> if_gnt pulses.
//   Next cycle: mem_req=1, mem_addr=0x100, addr_sel=0, mem_be all ones.
//   Ready after 3 cycles with mem_rdata=0xDEAD -> if_rvalid=1, rsp_rdata=0xDEAD.
//  Priority: d_req and if_req both high in IDLE -> d_gnt wins, addr_sel=1.
//   Store with d_addr=0x2000, d_wdata=0x55, d_be=4'b0011 appears on mem_* and stays stable through 5 wait cycles.
//  Starvation guard: MAX_D_STREAK=4, d_req and if_req held high, immediate mem_ready.
//   Required grant sequence: D, D, D, D, IF, D, D, D, D, IF.
//  Watchdog: TIMEOUT_CYC=8, mem_ready held 0 -> after 8 BUSY cycles the owner's rvalid=1 with rsp_err=1, then IDLE.
//   Same test with TIMEOUT_CYC=0 -> still BUSY after 1000 cycles.
//  Reset mid-operation: assert rst_n=0 while in BUSY_D -> mem_req falls immediately and no d_rvalid is produced.
//   After release: IDLE, counters 0, next if_req granted normally.
//  Invariant assertions for all tests: no gnt outside IDLE; gnt pulses mutually exclusive; rvalid pulses mutually exclusive.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types and widths for the memory-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int XBYTES = XLEN / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_IF,
        ARB_BUSY_D
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } mem_owner_e;

endpackage

// File: rtl/mem_port_arbiter_mx2.sv
// Two-input address mux choosing between fetch and data addresses.
// Latency: purely combinational.
// Backpressure: none; follows its select.
module mem_port_arbiter_mx2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? a1 : a0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (D), one transaction in flight.
// Latency: gnt same cycle as request in IDLE; earliest rvalid one cycle after gnt.
// Backpressure: requesters hold req until gnt; bus stalls via mem_ready, watchdog aborts hangs.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XBYTES-1:0] d_be,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XBYTES-1:0] mem_be,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              addr_sel
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int WAIT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WD_EN    = (TIMEOUT_CYC > 0);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    arb_state_e          state;
    mem_owner_e          owner;
    logic [STREAK_W-1:0] streak;
    logic [WAIT_W-1:0]   wait_cnt;

    logic            idle;
    logic            d_win;
    logic            if_win;
    logic            done;
    logic            wd_fire;
    logic            finish;
    logic [XLEN-1:0] addr_next;

    assign idle = (state == ARB_IDLE);

    // Grant decision: data first unless fetch has waited out a full streak.
    always_comb begin
        d_win  = 1'b0;
        if_win = 1'b0;
        if (d_req && !(if_req && (streak == STREAK_MAX))) begin
            d_win = 1'b1;
        end else if (if_req) begin
            if_win = 1'b1;
        end
    end

    assign if_gnt = idle && if_win;
    assign d_gnt  = idle && d_win;

    // The grant decision steers the mux; its output is captured only on a grant.
    mem_port_arbiter_mx2 #(
        .W (XLEN)
    ) u_addr_mx2 (
        .a0 (if_addr),
        .a1 (d_addr),
        .s  (d_win),
        .y  (addr_next)
    );

    // A transaction ends on bus completion or when the watchdog expires first.
    assign done    = !idle && mem_ready;
    assign wd_fire = WD_EN && !idle && !mem_ready && (wait_cnt == WAIT_LAST);
    assign finish  = done || wd_fire;

    assign if_rvalid = finish && (owner == OWN_IF);
    assign d_rvalid  = finish && (owner == OWN_D);
    assign rsp_err   = wd_fire;
    assign rsp_rdata = mem_rdata;
    assign addr_sel  = (owner == OWN_D);

    // Arbiter FSM: latch winner's request in IDLE, hold it on the bus until completion or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            streak    <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (d_win || if_win) begin
                        owner     <= d_win ? OWN_D : OWN_IF;
                        state     <= d_win ? ARB_BUSY_D : ARB_BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_addr  <= addr_next;
                        mem_we    <= d_win && d_we;
                        mem_be    <= d_win ? d_be : '1;
                        mem_wdata <= d_win ? d_wdata : '0;
                        wait_cnt  <= '0;
                    end
                    // Streak counts only D wins that make a waiting fetch wait longer.
                    if (if_win || !if_req) begin
                        streak <= '0;
                    end else if (d_win && (streak != STREAK_MAX)) begin
                        streak <= streak + 1'b1;
                    end
                end
                ARB_BUSY_IF, ARB_BUSY_D: begin
                    if (finish) begin
                        state   <= ARB_IDLE;
                        mem_req <= 1'b0;
                    end else if (WD_EN) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    logic              clk;
    logic              rst_n;

    logic              if_req;
    logic [XLEN-1:0]   if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic              d_req;
    logic              d_we;
    logic [XBYTES-1:0] d_be;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [XBYTES-1:0] mem_be;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              addr_sel;

    // second instance with the watchdog disabled
    logic              z_if_req;
    logic [XLEN-1:0]   z_if_addr;
    logic              z_if_gnt;
    logic              z_if_rvalid;
    logic              z_d_gnt;
    logic              z_d_rvalid;
    logic [XLEN-1:0]   z_rsp_rdata;
    logic              z_rsp_err;
    logic              z_mem_req;
    logic              z_mem_we;
    logic [XBYTES-1:0] z_mem_be;
    logic [XLEN-1:0]   z_mem_addr;
    logic [XLEN-1:0]   z_mem_wdata;
    logic              z_addr_sel;

    mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .addr_sel(addr_sel)
    );

    mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYC(0)) dut_nowd (
        .clk(clk), .rst_n(rst_n),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_gnt(z_if_gnt), .if_rvalid(z_if_rvalid),
        .d_req(1'b0), .d_we(1'b0), .d_be('0), .d_addr('0), .d_wdata('0),
        .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_be(z_mem_be), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_ready(1'b0), .mem_rdata('0),
        .addr_sel(z_addr_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              is_d;
        bit              err;
        bit              chk_data;
        logic [XLEN-1:0] rdata;
    } rsp_t;

    bit   exp_gnt[$];   // 1 = D grant expected, 0 = IF grant expected
    rsp_t exp_rsp[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ready_delay = -1;   // BUSY cycles before mem_ready; -1 = never

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic rsp_t mk_rsp(input bit is_d, input bit err, input bit chk, input logic [XLEN-1:0] rd);
        rsp_t r;
        r.is_d = is_d; r.err = err; r.chk_data = chk; r.rdata = rd;
        return r;
    endfunction

    // bus model: raise mem_ready after ready_delay BUSY cycles
    int bcnt;
    initial begin
        mem_ready = 1'b0;
        bcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_req) begin
                mem_ready = (ready_delay >= 0) && (bcnt == ready_delay);
                bcnt++;
            end else begin
                mem_ready = 1'b0;
                bcnt = 0;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_gnt || d_gnt) begin
                check("gnt_exclusive", {63'd0, if_gnt && d_gnt}, 64'd0);
                check("gnt_only_idle", {63'd0, mem_req}, 64'd0);
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", {62'd0, if_gnt, d_gnt}, 64'd0);
                end else begin
                    bit e;
                    e = exp_gnt.pop_front();
                    check("gnt_order", {63'd0, d_gnt}, {63'd0, e});
                end
            end
            if (if_rvalid || d_rvalid) begin
                check("rvalid_exclusive", {63'd0, if_rvalid && d_rvalid}, 64'd0);
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", {62'd0, if_rvalid, d_rvalid}, 64'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_owner", {63'd0, d_rvalid}, {63'd0, r.is_d});
                    check("rsp_err", {63'd0, rsp_err}, {63'd0, r.err});
                    if (r.chk_data) check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, r.rdata});
                end
            end
        end
    end

    task automatic wait_gnt(input bit want_d, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (want_d ? d_gnt : if_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {63'd0, ok}, 64'd1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_gnt.size() == 0 && exp_rsp.size() == 0) break;
            @(negedge clk); #1;
        end
        check(name, 64'(exp_gnt.size() + exp_rsp.size()), 64'd0);
        exp_gnt.delete();
        exp_rsp.delete();
    endtask

    initial begin
        int n;
        int k;
        bit seen;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        z_if_req = 1'b0; z_if_addr = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req",   {63'd0, mem_req}, 64'd0);
        check("rst_addr_sel",  {63'd0, addr_sel}, 64'd0);
        check("rst_mem_addr",  {32'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_mem_be_we", {59'd0, mem_be, mem_we}, 64'd0);
        check("rst_outputs",   {60'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic fetch, ready in 4th BUSY cycle
        ready_delay = 3;
        mem_rdata = 32'h0000_DEAD;
        exp_gnt.push_back(1'b0);
        exp_rsp.push_back(mk_rsp(1'b0, 1'b0, 1'b1, 32'h0000_DEAD));
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        wait_gnt(1'b0, "if_gnt_seen");
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("if_mem_req",  {63'd0, mem_req}, 64'd1);
        check("if_mem_addr", {32'd0, mem_addr}, 64'h100);
        check("if_addr_sel", {63'd0, addr_sel}, 64'd0);
        check("if_mem_be",   {60'd0, mem_be}, 64'hF);
        check("if_mem_we",   {63'd0, mem_we}, 64'd0);
        drain("drain_fetch");

        // data priority with a store held over 5 wait cycles, then pending IF
        ready_delay = 5;
        mem_rdata = 32'h0000_BEEF;
        exp_gnt.push_back(1'b1);
        exp_gnt.push_back(1'b0);
        exp_rsp.push_back(mk_rsp(1'b1, 1'b0, 1'b0, '0));
        exp_rsp.push_back(mk_rsp(1'b0, 1'b0, 1'b1, 32'h0000_BEEF));
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55; d_be = 4'b0011;
        if_req = 1'b1; if_addr = 32'h300;
        wait_gnt(1'b1, "prio_d_gnt_seen");
        check("prio_if_gnt_low", {63'd0, if_gnt}, 64'd0);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'hFFFF_FFFF; d_addr = 32'h9999; d_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("store_hold",
                  {mem_req, mem_we, addr_sel, mem_be, mem_addr[15:0], mem_wdata[15:0]},
                  {1'b1, 1'b1, 1'b1, 4'b0011, 16'h2000, 16'h0055});
        end
        wait_gnt(1'b0, "prio_if_after_d");
        @(posedge clk); #1;
        if_req = 1'b0;
        drain("drain_prio");

        // starvation guard with immediate ready
        ready_delay = 0;
        mem_rdata = 32'h0000_1234;
        for (int i = 0; i < 10; i++) begin
            bit isd;
            isd = !(i == 4 || i == 9);
            exp_gnt.push_back(isd);
            exp_rsp.push_back(mk_rsp(isd, 1'b0, 1'b1, 32'h0000_1234));
        end
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h500;
        n = 0;
        for (int i = 0; i < 100 && n < 10; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) n++;
        end
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0;
        check("streak_grant_count", 64'(n), 64'd10);
        drain("drain_streak");

        // watchdog abort after 8 BUSY cycles
        ready_delay = -1;
        exp_gnt.push_back(1'b1);
        exp_rsp.push_back(mk_rsp(1'b1, 1'b1, 1'b0, '0));
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        wait_gnt(1'b1, "wd_gnt_seen");
        @(posedge clk); #1;
        d_req = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (d_rvalid) begin
                k = i;
                break;
            end
        end
        check("wd_abort_cycle", 64'(k), 64'd8);
        @(negedge clk);
        check("wd_back_idle", {63'd0, mem_req}, 64'd0);
        drain("drain_wd");

        // reset while a store is in BUSY_D
        exp_gnt.push_back(1'b1);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hAA; d_be = 4'hF;
        wait_gnt(1'b1, "rst_d_gnt_seen");
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_mem_req", {63'd0, mem_req}, 64'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (d_rvalid || if_rvalid) seen = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (d_rvalid || if_rvalid) seen = 1'b1;
        end
        check("rst_no_rvalid", {63'd0, seen}, 64'd0);
        check("rst_idle_regs", {30'd0, mem_req, addr_sel, mem_addr}, 64'd0);
        ready_delay = 1;
        mem_rdata = 32'h0000_0777;
        exp_gnt.push_back(1'b0);
        exp_rsp.push_back(mk_rsp(1'b0, 1'b0, 1'b1, 32'h0000_0777));
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h600;
        wait_gnt(1'b0, "post_rst_if_gnt");
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("post_rst_mem_addr", {32'd0, mem_addr}, 64'h600);
        drain("drain_post_rst");

        // watchdog disabled: stays BUSY indefinitely
        @(posedge clk); #1;
        z_if_req = 1'b1; z_if_addr = 32'h700;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (z_if_gnt) begin
                seen = 1'b1;
                break;
            end
        end
        check("nowd_gnt_seen", {63'd0, seen}, 64'd1);
        @(posedge clk); #1;
        z_if_req = 1'b0;
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (z_if_rvalid || z_d_rvalid || z_rsp_err) seen = 1'b1;
        end
        check("nowd_no_rsp", {63'd0, seen}, 64'd0);
        check("nowd_still_busy", {31'd0, z_mem_req, z_mem_addr}, {31'd0, 1'b1, 32'h700});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
